// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the byte-serial memory arbiter: size codes, FSM
// encoding, data/byte widths and byte lane helpers.
package mem_arbiter_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 3;

  localparam logic [1:0] SZ_BYTE     = 2'b00;
  localparam logic [1:0] SZ_HALF     = 2'b01;
  localparam logic [1:0] SZ_WORD     = 2'b10;
  localparam logic [1:0] SZ_WORD_ALT = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Latched transfer descriptor (address kept separately: its width is a parameter)
  typedef struct packed {
    logic              we;
    logic [CNT_W-1:0]  nbytes;
    logic [DATA_W-1:0] wdata;
  } xfer_t;

  function automatic logic [CNT_W-1:0] size_to_bytes(input logic [1:0] sz);
    logic [CNT_W-1:0] n;
    case (sz)
      SZ_BYTE:     n = CNT_W'(1);
      SZ_HALF:     n = CNT_W'(2);
      SZ_WORD:     n = CNT_W'(4);
      SZ_WORD_ALT: n = CNT_W'(4);
      default:     n = CNT_W'(4);
    endcase
    return n;
  endfunction

  function automatic logic [BYTE_W-1:0] get_byte(input logic [DATA_W-1:0] w,
                                                 input logic [1:0]        k);
    return BYTE_W'(w >> (BYTE_W * k));
  endfunction

  function automatic logic [DATA_W-1:0] put_byte(input logic [DATA_W-1:0] w,
                                                 input logic [1:0]        k,
                                                 input logic [BYTE_W-1:0] b);
    return w | (DATA_W'(b) << (BYTE_W * k));
  endfunction

endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// Combinational winner select: fixed priority (highest index) or round-robin
// starting one past the last winner.
module arb_pick #(
  parameter int unsigned NCH     = 2,
  parameter int unsigned RR_MODE = 0,
  parameter int unsigned IDXW    = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic [NCH-1:0]  req_i,
  input  logic [IDXW-1:0] ptr_i,
  output logic [IDXW-1:0] win_c_o,
  output logic            any_c_o
);

  always_comb begin
    win_c_o = '0;
    any_c_o = |req_i;
    if (RR_MODE != 0) begin
      // Walk offsets from farthest to nearest so the nearest requester wins
      for (int off = int'(NCH); off > 0; off--) begin
        int idx;
        idx = (int'(ptr_i) + off) % int'(NCH);
        if (req_i[idx]) win_c_o = IDXW'(idx);
      end
    end else begin
      for (int i = 0; i < int'(NCH); i++) begin
        if (req_i[i]) win_c_o = IDXW'(i);
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Multi-channel arbiter serialising byte/half/word accesses onto a single
// byte-wide synchronous RAM port.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned NCH     = 2,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned RR_MODE = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NCH-1:0]           req,
  input  logic [NCH-1:0]           we,
  input  logic [2*NCH-1:0]         size,
  input  logic [ADDR_W*NCH-1:0]    addr,
  input  logic [DATA_W*NCH-1:0]    wdata,
  output logic [NCH-1:0]           done,
  output logic [DATA_W-1:0]        rdata,
  output logic [NCH-1:0]           stall,
  output logic [ADDR_W-1:0]        mem_a,
  output logic [BYTE_W-1:0]        mem_dout,
  output logic                     mem_wr,
  input  logic [BYTE_W-1:0]        mem_din
);

  localparam int unsigned IDXW = (NCH > 1) ? $clog2(NCH) : 1;

  state_e              state_q, state_d;
  logic [IDXW-1:0]     win_q, win_d;
  logic [IDXW-1:0]     ptr_q, ptr_d;
  xfer_t               xf_q, xf_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   buf_q, buf_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [NCH-1:0]      done_q, done_d;
  logic [ADDR_W-1:0]   mem_a_q, mem_a_d;
  logic [BYTE_W-1:0]   mem_dout_q, mem_dout_d;
  logic                mem_wr_q, mem_wr_d;

  logic [IDXW-1:0]     pick_idx;
  logic                pick_any;
  logic [CNT_W-1:0]    last_k;
  logic [ADDR_W-1:0]   next_a;

  logic [ADDR_W-1:0]   ch_addr  [NCH];
  logic [DATA_W-1:0]   ch_wdata [NCH];
  logic [1:0]          ch_size  [NCH];

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    assign ch_addr[g]  = addr[g*ADDR_W +: ADDR_W];
    assign ch_wdata[g] = wdata[g*DATA_W +: DATA_W];
    assign ch_size[g]  = size[2*g +: 2];
  end

  arb_pick #(
    .NCH     (NCH),
    .RR_MODE (RR_MODE),
    .IDXW    (IDXW)
  ) u_pick (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .win_c_o (pick_idx),
    .any_c_o (pick_any)
  );

  assign last_k = xf_q.nbytes - CNT_W'(1);
  assign next_a = addr_q + ADDR_W'(cnt_q) + ADDR_W'(1);

  // Next-state and registered-output logic; RAM port idles at zero by default
  always_comb begin
    state_d    = state_q;
    win_d      = win_q;
    ptr_d      = ptr_q;
    xf_d       = xf_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    buf_d      = buf_q;
    rdata_d    = rdata_q;
    done_d     = '0;
    mem_a_d    = '0;
    mem_dout_d = '0;
    mem_wr_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          win_d       = pick_idx;
          xf_d.we     = we[pick_idx];
          xf_d.nbytes = size_to_bytes(ch_size[pick_idx]);
          xf_d.wdata  = ch_wdata[pick_idx];
          addr_d      = ch_addr[pick_idx];
          cnt_d       = '0;
          buf_d       = '0;
          mem_a_d     = ch_addr[pick_idx];
          mem_wr_d    = we[pick_idx];
          mem_dout_d  = we[pick_idx] ? get_byte(ch_wdata[pick_idx], 2'd0) : '0;
          state_d     = ST_XFER;
        end
      end

      ST_XFER: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (xf_q.we) begin
          if (cnt_q == last_k) begin
            state_d = ST_DONE;
            done_d  = NCH'(1) << win_q;
          end else begin
            mem_a_d    = next_a;
            mem_dout_d = get_byte(xf_q.wdata, 2'(cnt_q + CNT_W'(1)));
            mem_wr_d   = 1'b1;
          end
        end else begin
          // RAM returns the byte addressed in the previous cycle
          if (cnt_q != '0) buf_d = put_byte(buf_q, 2'(cnt_q - CNT_W'(1)), mem_din);
          if (cnt_q < last_k) mem_a_d = next_a;
          if (cnt_q == xf_q.nbytes) begin
            state_d = ST_DONE;
            done_d  = NCH'(1) << win_q;
            rdata_d = buf_d;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        ptr_d   = win_q;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      win_q      <= '0;
      ptr_q      <= IDXW'(NCH - 1);
      xf_q       <= '0;
      addr_q     <= '0;
      cnt_q      <= '0;
      buf_q      <= '0;
      rdata_q    <= '0;
      done_q     <= '0;
      mem_a_q    <= '0;
      mem_dout_q <= '0;
      mem_wr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      win_q      <= win_d;
      ptr_q      <= ptr_d;
      xf_q       <= xf_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      buf_q      <= buf_d;
      rdata_q    <= rdata_d;
      done_q     <= done_d;
      mem_a_q    <= mem_a_d;
      mem_dout_q <= mem_dout_d;
      mem_wr_q   <= mem_wr_d;
    end
  end

  assign done     = done_q;
  assign rdata    = rdata_q;
  assign stall    = req & ~done_q;
  assign mem_a    = mem_a_q;
  assign mem_dout = mem_dout_q;
  assign mem_wr   = mem_wr_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench: a fixed-priority and a round-robin arbiter share stimulus;
// a transaction-level model predicts service order, RAM writes, rdata and done timing.
module tb_mem_arbiter;

  typedef struct {
    logic [1:0]  ch;
    int          cyc;
    logic [31:0] rdata;
  } done_t;

  typedef struct {
    logic [31:0] a;
    logic [7:0]  b;
  } wr_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  logic [1:0]  req_r   [2];
  logic [1:0]  we_b;
  logic [3:0]  size_b;
  logic [63:0] addr_b;
  logic [63:0] wdata_b;
  logic [1:0]  done_w  [2];
  logic [31:0] rdata_w [2];
  logic [1:0]  stall_w [2];
  logic [31:0] a_w     [2];
  logic [7:0]  dout_w  [2];
  logic        wr_w    [2];
  logic [7:0]  din_r   [2];

  logic        c_we    [2];
  logic [1:0]  c_size  [2];
  logic [31:0] c_addr  [2];
  logic [31:0] c_wdata [2];

  done_t expd [2][$];
  wr_t   expw [2][$];
  int          ptr_m   [2];
  logic [31:0] last_rd [2];

  logic [7:0] ref_mem  [logic [32:0]];
  logic [7:0] phys_mem [logic [32:0]];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_arbiter #(.NCH(2), .ADDR_W(32), .RR_MODE(0)) u_fix (
    .clk(clk), .rst(rst), .req(req_r[0]), .we(we_b), .size(size_b), .addr(addr_b),
    .wdata(wdata_b), .done(done_w[0]), .rdata(rdata_w[0]), .stall(stall_w[0]),
    .mem_a(a_w[0]), .mem_dout(dout_w[0]), .mem_wr(wr_w[0]), .mem_din(din_r[0]));

  mem_arbiter #(.NCH(2), .ADDR_W(32), .RR_MODE(1)) u_rr (
    .clk(clk), .rst(rst), .req(req_r[1]), .we(we_b), .size(size_b), .addr(addr_b),
    .wdata(wdata_b), .done(done_w[1]), .rdata(rdata_w[1]), .stall(stall_w[1]),
    .mem_a(a_w[1]), .mem_dout(dout_w[1]), .mem_wr(wr_w[1]), .mem_din(din_r[1]));

  function automatic logic [7:0] init_b(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] ref_rd(input int u, input logic [31:0] a);
    logic [32:0] key;
    key = {1'(u), a};
    return ref_mem.exists(key) ? ref_mem[key] : init_b(a);
  endfunction

  function automatic logic [7:0] phys_rd(input int u, input logic [31:0] a);
    logic [32:0] key;
    key = {1'(u), a};
    return phys_mem.exists(key) ? phys_mem[key] : init_b(a);
  endfunction

  // Byte-wide synchronous RAM behind each arbiter
  always @(posedge clk) begin
    for (int u = 0; u < 2; u++) begin
      din_r[u] <= phys_rd(u, a_w[u]);
      if (wr_w[u]) phys_mem[{1'(u), a_w[u]}] = dout_w[u];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic mon(input int u);
    done_t e;
    wr_t   w;
    chk($sformatf("stall%0d", u), 64'(stall_w[u]), 64'(req_r[u] & ~done_w[u]));
    if (done_w[u] != 2'b00) begin
      if (expd[u].size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL unexpected_done%0d: got %b expected none (cycle %0d)", u, done_w[u], cyc);
      end else begin
        e = expd[u].pop_front();
        chk($sformatf("done_ch%0d", u), 64'(done_w[u]), 64'(e.ch));
        chk($sformatf("done_cyc%0d", u), 64'(cyc), 64'(e.cyc));
        chk($sformatf("rdata%0d", u), 64'(rdata_w[u]), 64'(e.rdata));
      end
    end
    if (wr_w[u]) begin
      if (expw[u].size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL unexpected_wr%0d: got a=%0h d=%0h expected none", u, a_w[u], dout_w[u]);
      end else begin
        w = expw[u].pop_front();
        chk($sformatf("mem_a%0d", u), 64'(a_w[u]), 64'(w.a));
        chk($sformatf("mem_dout%0d", u), 64'(dout_w[u]), 64'(w.b));
      end
    end else begin
      chk($sformatf("dout_idle%0d", u), 64'(dout_w[u]), 64'h0);
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b1) begin
      mon(0);
      mon(1);
    end
  end

  task automatic drive_bus();
    for (int i = 0; i < 2; i++) begin
      we_b[i]           = c_we[i];
      size_b[2*i +: 2]  = c_size[i];
      addr_b[32*i +: 32]  = c_addr[i];
      wdata_b[32*i +: 32] = c_wdata[i];
    end
  endtask

  // Transaction-level prediction: order by arbitration rule, then sequential effects
  task automatic predict(input int u, input logic [1:0] set, input int t0);
    logic [1:0]  rem;
    int          t, w, n;
    logic [31:0] a, d;
    done_t       e;
    wr_t         wr;
    rem = set;
    t   = t0;
    while (rem != 2'b00) begin
      w = -1;
      if (u == 0) begin
        for (int i = 0; i < 2; i++) if (rem[i]) w = i;
      end else begin
        for (int off = 1; off <= 2 && w < 0; off++)
          if (rem[(ptr_m[u] + off) % 2]) w = (ptr_m[u] + off) % 2;
        ptr_m[u] = w;
      end
      rem[w] = 1'b0;
      n = (c_size[w] == 2'b00) ? 1 : (c_size[w] == 2'b01) ? 2 : 4;
      if (c_we[w]) begin
        for (int k = 0; k < n; k++) begin
          a = c_addr[w] + 32'(k);
          d = c_wdata[w] >> (8 * k);
          wr.a = a; wr.b = d[7:0];
          expw[u].push_back(wr);
          ref_mem[{1'(u), a}] = d[7:0];
        end
        e.cyc = t + n + 1;
      end else begin
        d = 32'h0;
        for (int k = 0; k < n; k++) begin
          a = c_addr[w] + 32'(k);
          d = d | (32'(ref_rd(u, a)) << (8 * k));
        end
        last_rd[u] = d;
        e.cyc = t + n + 2;
      end
      e.ch    = 2'b01 << w;
      e.rdata = last_rd[u];
      expd[u].push_back(e);
      t = e.cyc + 1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    req_r[0] = 2'b00;
    req_r[1] = 2'b00;
    for (int u = 0; u < 2; u++) begin
      ptr_m[u] = 1;
      last_rd[u] = 32'h0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int u = 0; u < 2; u++) begin
      chk($sformatf("rst_done%0d", u), 64'(done_w[u]), 64'h0);
      chk($sformatf("rst_rdata%0d", u), 64'(rdata_w[u]), 64'h0);
      chk($sformatf("rst_wr%0d", u), 64'(wr_w[u]), 64'h0);
      chk($sformatf("rst_a%0d", u), 64'(a_w[u]), 64'h0);
      chk($sformatf("rst_dout%0d", u), 64'(dout_w[u]), 64'h0);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Issue one request set (held until each channel's done), optionally as a 1-cycle pulse
  task automatic run_round(input logic [1:0] set, input bit pulse);
    logic [1:0] pend [2];
    int budget;
    drive_bus();
    predict(0, set, cyc);
    predict(1, set, cyc);
    req_r[0] = set; req_r[1] = set;
    pend[0]  = set; pend[1]  = set;
    budget = 0;
    while ((pend[0] | pend[1]) != 2'b00 && budget < 60) begin
      @(posedge clk);
      #1;
      budget++;
      if (pulse && budget == 1) begin
        req_r[0] = 2'b00; req_r[1] = 2'b00;
        we_b = 2'($urandom); size_b = 4'($urandom);
        addr_b = {$urandom, $urandom}; wdata_b = {$urandom, $urandom};
      end
      for (int u = 0; u < 2; u++) begin
        pend[u]  = pend[u] & ~done_w[u];
        req_r[u] = req_r[u] & ~done_w[u];
      end
    end
    if ((pend[0] | pend[1]) != 2'b00) begin
      vectors++; miscompares++;
      $display("FAIL round_timeout: pending %b/%b after %0d cycles", pend[0], pend[1], budget);
      for (int u = 0; u < 2; u++) begin
        expd[u].delete();
        expw[u].delete();
      end
      do_reset();
    end else begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [1:0] set;
    bit pulse;
    wr_t wr;
    rst = 1'b0;
    req_r[0] = 2'b00; req_r[1] = 2'b00;
    for (int i = 0; i < 2; i++) begin
      c_we[i] = 1'b0; c_size[i] = 2'b00; c_addr[i] = 32'h0; c_wdata[i] = 32'h0;
    end
    drive_bus();
    for (int u = 0; u < 2; u++) begin
      for (int k = 0; k < 4; k++) begin
        ref_mem[{1'(u), 32'h200 + 32'(k)}]  = 8'(8'h11 * (k + 1));
        phys_mem[{1'(u), 32'h200 + 32'(k)}] = 8'(8'h11 * (k + 1));
      end
    end
    do_reset();

    // Single byte write on ch1
    c_we[1] = 1'b1; c_size[1] = 2'b00; c_addr[1] = 32'h100; c_wdata[1] = 32'h0000_00AB;
    run_round(2'b10, 1'b0);

    // Word read on ch0 from preloaded bytes
    c_we[0] = 1'b0; c_size[0] = 2'b10; c_addr[0] = 32'h200; c_wdata[0] = 32'h0;
    run_round(2'b01, 1'b0);

    // Simultaneous requests
    c_we[1] = 1'b1; c_size[1] = 2'b01; c_addr[1] = 32'h204; c_wdata[1] = 32'h1234_5678;
    c_we[0] = 1'b0; c_size[0] = 2'b11; c_addr[0] = 32'h202;
    run_round(2'b11, 1'b0);

    // Wrapping half write issued as a one-cycle pulse with inputs scrambled afterwards
    c_we[0] = 1'b1; c_size[0] = 2'b01; c_addr[0] = 32'hFFFF_FFFF; c_wdata[0] = 32'h0000_BEEF;
    run_round(2'b01, 1'b1);
    c_we[1] = 1'b0; c_size[1] = 2'b01; c_addr[1] = 32'hFFFF_FFFF;
    run_round(2'b10, 1'b0);

    // Reset during a word write after two bytes have gone out
    c_we[1] = 1'b1; c_size[1] = 2'b10; c_addr[1] = 32'h300; c_wdata[1] = 32'hCAFE_F00D;
    drive_bus();
    for (int u = 0; u < 2; u++) begin
      wr.a = 32'h300; wr.b = 8'h0D; expw[u].push_back(wr); ref_mem[{1'(u), wr.a}] = wr.b;
      wr.a = 32'h301; wr.b = 8'hF0; expw[u].push_back(wr); ref_mem[{1'(u), wr.a}] = wr.b;
    end
    req_r[0] = 2'b10; req_r[1] = 2'b10;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    req_r[0] = 2'b00; req_r[1] = 2'b00;
    #1;
    for (int u = 0; u < 2; u++) begin
      chk($sformatf("abort_wr%0d", u), 64'(wr_w[u]), 64'h0);
      chk($sformatf("abort_a%0d", u), 64'(a_w[u]), 64'h0);
      chk($sformatf("abort_done%0d", u), 64'(done_w[u]), 64'h0);
      chk($sformatf("abort_wq%0d", u), 64'(expw[u].size()), 64'h0);
    end
    do_reset();

    // Continuous contention from reset: round-robin alternates 0,1,0,1
    c_we[0] = 1'b1; c_size[0] = 2'b00; c_addr[0] = 32'h210; c_wdata[0] = 32'h55;
    c_we[1] = 1'b0; c_size[1] = 2'b10; c_addr[1] = 32'h300;
    run_round(2'b11, 1'b0);
    run_round(2'b11, 1'b0);

    // Randomised traffic concentrated on a small window and the wrap region
    for (int r = 0; r < 60; r++) begin
      set = 2'($urandom_range(1, 3));
      for (int i = 0; i < 2; i++) begin
        c_we[i]    = 1'($urandom);
        c_size[i]  = 2'($urandom);
        c_wdata[i] = $urandom;
        case ($urandom_range(0, 2))
          0:       c_addr[i] = 32'h200 + 32'($urandom_range(0, 15));
          1:       c_addr[i] = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
          default: c_addr[i] = $urandom;
        endcase
      end
      pulse = (set != 2'b11) && ($urandom_range(0, 3) == 0);
      run_round(set, pulse);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end

    repeat (4) @(posedge clk);
    #1;
    for (int u = 0; u < 2; u++) begin
      chk($sformatf("done_q_empty%0d", u), 64'(expd[u].size()), 64'h0);
      chk($sformatf("wr_q_empty%0d", u), 64'(expw[u].size()), 64'h0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
